note_sequencer: RTL
===================

// Module: note_sequencer
// PURPOSE
//  Producer side of the packed 27-bit `notes` bus consumed by the 3-voice note decoder.
//  Accepts timed note events over a valid/ready handshake, holds each voice's note code
//  and waveform select for the requested number of duration ticks, then inserts a
//  one-tick release. Drives the registered, packed frame straight into the decoder's `notes`.
// PARAMETERS
//  TICK_DIV  16'd50000  clk cycles per duration tick; legal range 2..65535
//  DUR_W     8          width of the duration field, in ticks
// PORTS
//  clk       in   1      system clock; the only clock
//  reset     in   1      synchronous, active-high reset
//  ev_valid  in   1      event offered
//  ev_ready  out  1      event can be accepted this cycle
//  ev_voice  in   2      target voice 0..2; 3 = invalid
//  ev_note   in   7      note code; 0 = rest (voice silent)
//  ev_wave   in   2      waveform: 0 sine, 1 triangle, 2 square, 3 saw
//  ev_dur    in   DUR_W  duration in ticks; 0 = hold until replaced
//  stop      in   1      silence all voices
//  notes     out  27     packed frame: voice v -> note [9v+6:9v], wave [9v+8:9v+7]
//  active    out  3      bit v = voice v in PLAY
//  tick      out  1      one-cycle pulse per duration tick
//  drop      out  1      one-cycle pulse when an event for voice 3 is accepted
// BEHAVIOUR
//  Reset (clk edge with reset=1): notes=0, active=0, tick=0, drop=0, tick counter=0,
//   every voice IDLE. ev_ready=0 while reset=1.
//  Tick: counter runs 0..TICK_DIV-1. tick=1 on the cycle the counter equals TICK_DIV-1,
//   then the counter wraps to 0. stop does not affect the counter.
//  Voice FSM, per voice, with states IDLE, PLAY and REL:
//   IDLE: notes field = 9'b0.
//   PLAY: field = {wave, note}. Holds dur_cnt and a hold flag (ev_dur==0).
//   REL: note bits = 0, wave bits kept. Lasts until the next tick, then goes to IDLE.
//   PLAY, not hold: on tick, if dur_cnt==1 go to REL, else decrement dur_cnt.
//   PLAY, hold: ignores ticks.
//  ev_ready = !reset && !stop && (ev_voice==3 || state[ev_voice]!=PLAY || hold[ev_voice]).
//   ev_ready is combinational from the registered state and the ev_voice input.
//  Accept (ev_valid && ev_ready):
//   Voices 0..2: the target voice loads note, wave and dur_cnt=ev_dur, sets hold=(ev_dur==0)
//   and enters PLAY. This holds from IDLE, from REL (the release is cut) and from a held PLAY
//   (replaced with no release). The new field appears on `notes` the next cycle: latency 1.
//   Voice 3: the event is discarded, drop=1 on the next cycle, and `notes` is unchanged.
//  A note code of 0 is legal. The voice enters PLAY with a silent field and times out normally.
//  Accept and tick on the same cycle for the target voice: the accept wins, and dur_cnt=ev_dur
//   is not decremented by that tick. Other voices process the tick normally.
//  stop=1: all voices go to IDLE at the next edge (notes=0, active=0), and no event is accepted.
//  reset mid-operation: all state is cleared per the reset line, whatever the FSM state.
//  All outputs are registered except ev_ready. dur_cnt is DUR_W bits and never wraps:
//   it is reloaded only on accept.
// TESTING (TICK_DIV=4, DUR_W=8)
//  1. Hold reset=1 for 3 cycles -> notes=0, active=0, ev_ready=0. Release reset ->
//     tick pulses every 4th cycle, first pulse 4 cycles after reset falls.
//  2. Accept voice0 note=40 wave=2 dur=3 -> next cycle notes[8:0]=9'h128, active=3'b001.
//     After the 3rd tick notes[8:0]=9'h100 (REL). After the 4th tick notes[8:0]=0, active=0.
//  3. During test 2 PLAY, offer voice0 note=50 -> ev_ready=0 until REL. It is accepted in REL,
//     notes[8:0]={wave,7'd50} the next cycle, and no IDLE cycle is seen.
//  4. voice2 note=60 wave=3 dur=0 -> notes[26:18]=9'h1BC for 20 ticks. Then voice2 note=61
//     is accepted immediately and notes[26:18]=9'h1BD with no zero cycle.
//  5. ev_voice=3 with valid -> ev_ready=1, drop pulse for 1 cycle, notes unchanged.
//     stop=1 while 3 voices play -> notes=0 and active=0 next cycle, ev_ready=0 while stop=1.
//  6. Accept voice1 dur=2 on a tick cycle -> voice1 stays in PLAY for exactly 2 further ticks.
//     The other voices' counts decrement on that same tick.

Source files
------------

// File: rtl/note_sequencer.sv
// Timed note-event sequencer driving the packed 27-bit frame of the 3-voice note decoder.
// Each voice plays for a number of duration ticks, then releases for one tick before going idle.
module note_sequencer #(
   parameter logic [15:0] TICK_DIV = 16'd50000,
   parameter int          DUR_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ev_valid,
   output logic             ev_ready,
   input  logic [1:0]       ev_voice,
   input  logic [6:0]       ev_note,
   input  logic [1:0]       ev_wave,
   input  logic [DUR_W-1:0] ev_dur,
   input  logic             stop,
   output logic [26:0]      notes,
   output logic [2:0]       active,
   output logic             tick,
   output logic             drop
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      REL  = 2'd2
   } voice_state_e;

   logic [15:0]      cnt_r;
   logic             tick_r;

   voice_state_e     state_r     [3];
   voice_state_e     state_nxt_s [3];
   logic [DUR_W-1:0] dur_r       [3];
   logic [DUR_W-1:0] dur_nxt_s   [3];
   logic             hold_r      [3];
   logic             hold_nxt_s  [3];
   logic [6:0]       note_r      [3];
   logic [6:0]       note_nxt_s  [3];
   logic [1:0]       wave_r      [3];
   logic [1:0]       wave_nxt_s  [3];

   logic             ev_ready_s;
   logic             accept_s;
   logic [26:0]      frame_nxt_s;
   logic [2:0]       active_nxt_s;
   logic [26:0]      notes_r;
   logic [2:0]       active_r;
   logic             drop_r;

   // Tick divider; tick_r is high exactly while the counter sits at TICK_DIV-1.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r  <= 16'd0;
         tick_r <= 1'b0;
      end else begin
         if (cnt_r == TICK_DIV - 16'd1) begin
            cnt_r <= 16'd0;
         end else begin
            cnt_r <= cnt_r + 16'd1;
         end
         tick_r <= (cnt_r == TICK_DIV - 16'd2);
      end
   end

   // Ready: a voice that is timing out a note refuses new events until its release.
   always_comb begin
      ev_ready_s = 1'b0;
      if (!reset && !stop) begin
         case (ev_voice)
            2'd0:    ev_ready_s = (state_r[0] != PLAY) || hold_r[0];
            2'd1:    ev_ready_s = (state_r[1] != PLAY) || hold_r[1];
            2'd2:    ev_ready_s = (state_r[2] != PLAY) || hold_r[2];
            default: ev_ready_s = 1'b1;
         endcase
      end else begin
         ev_ready_s = 1'b0;
      end
   end

   assign accept_s = ev_valid && ev_ready_s;

   // Per-voice next state; an accept overrides any tick for the targeted voice.
   always_comb begin
      for (int v = 0; v < 3; v++) begin
         state_nxt_s[v] = state_r[v];
         dur_nxt_s[v]   = dur_r[v];
         hold_nxt_s[v]  = hold_r[v];
         note_nxt_s[v]  = note_r[v];
         wave_nxt_s[v]  = wave_r[v];
         if (stop) begin
            state_nxt_s[v] = IDLE;
         end else if (accept_s && (ev_voice == 2'(v))) begin
            state_nxt_s[v] = PLAY;
            dur_nxt_s[v]   = ev_dur;
            hold_nxt_s[v]  = (ev_dur == '0);
            note_nxt_s[v]  = ev_note;
            wave_nxt_s[v]  = ev_wave;
         end else begin
            case (state_r[v])
               PLAY: begin
                  if (tick_r && !hold_r[v]) begin
                     if (dur_r[v] == DUR_W'(1)) begin
                        state_nxt_s[v] = REL;
                     end else begin
                        dur_nxt_s[v] = dur_r[v] - DUR_W'(1);
                     end
                  end else begin
                     state_nxt_s[v] = PLAY;
                  end
               end
               REL: begin
                  if (tick_r) begin
                     state_nxt_s[v] = IDLE;
                  end else begin
                     state_nxt_s[v] = REL;
                  end
               end
               IDLE:    state_nxt_s[v] = IDLE;
               default: state_nxt_s[v] = IDLE;
            endcase
         end
      end
   end

   // Frame assembly from next state so the decoder sees a new note one cycle after accept.
   always_comb begin
      frame_nxt_s  = 27'd0;
      active_nxt_s = 3'd0;
      for (int v = 0; v < 3; v++) begin
         case (state_nxt_s[v])
            PLAY: begin
               frame_nxt_s[9*v +: 9] = {wave_nxt_s[v], note_nxt_s[v]};
               active_nxt_s[v]       = 1'b1;
            end
            REL:     frame_nxt_s[9*v +: 9] = {wave_nxt_s[v], 7'd0};
            IDLE:    frame_nxt_s[9*v +: 9] = 9'd0;
            default: frame_nxt_s[9*v +: 9] = 9'd0;
         endcase
      end
   end

   // Voice state and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int v = 0; v < 3; v++) begin
            state_r[v] <= IDLE;
            dur_r[v]   <= '0;
            hold_r[v]  <= 1'b0;
            note_r[v]  <= 7'd0;
            wave_r[v]  <= 2'd0;
         end
         notes_r  <= 27'd0;
         active_r <= 3'd0;
         drop_r   <= 1'b0;
      end else begin
         for (int v = 0; v < 3; v++) begin
            state_r[v] <= state_nxt_s[v];
            dur_r[v]   <= dur_nxt_s[v];
            hold_r[v]  <= hold_nxt_s[v];
            note_r[v]  <= note_nxt_s[v];
            wave_r[v]  <= wave_nxt_s[v];
         end
         notes_r  <= frame_nxt_s;
         active_r <= active_nxt_s;
         drop_r   <= accept_s && (ev_voice == 2'd3);
      end
   end

   assign ev_ready = ev_ready_s;
   assign notes    = notes_r;
   assign active   = active_r;
   assign tick     = tick_r;
   assign drop     = drop_r;

endmodule
